// File: rtl/stackram_pkg.sv
// Shared defaults for the stackram register-file stack.
package stackram_pkg;
   localparam int STACKRAM_DEP = 3;   // address width
   localparam int STACKRAM_L   = 16;  // data word width
endpackage

// File: rtl/stackram.sv
// stackram: 2**dep x l flop-array stack memory with a combinational read port.
// The parent CPU computes sp/spdec; this block only stores and selects.
// Optional macro STACKRAM_BYPASS_EN forwards `in` to `out` while push=1
// (read path only; memory contents and write timing are unaffected).
module stackram
   import stackram_pkg::*;
#(
   parameter int dep = STACKRAM_DEP,
   parameter int l   = STACKRAM_L
) (
   input  logic [l-1:0]   in,
   input  logic           push,
   input  logic [dep-1:0] spdec,
   input  logic [dep-1:0] sp,
   input  logic           clk,
   output logic [l-1:0]   out,
   input  logic           reset
);

   localparam int DEPTH = 1 << dep;

   logic [DEPTH-1:0][l-1:0] mem;
   logic [dep-1:0]          spset;

   // Storage: synchronous clear wins over a simultaneous push.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[spdec] <= in;
      end
   end

   // Read select and combinational read data.
   always_comb begin
      spset = push ? spdec : sp;
`ifdef STACKRAM_BYPASS_EN
      out = push ? in : mem[spset];
`else
      out = mem[spset];
`endif
   end

endmodule

// File: tb/tb_stackram.sv
// Directed self-checking bench for stackram (default parameters).
module tb_stackram;

   logic [15:0] in;
   logic        push;
   logic [2:0]  spdec;
   logic [2:0]  sp;
   logic        clk;
   logic [15:0] out;
   logic        reset;

   int n_cmp = 0;
   int n_err = 0;

   stackram dut (
      .in(in), .push(push), .spdec(spdec), .sp(sp),
      .clk(clk), .out(out), .reset(reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] exp);
      #1;
      n_cmp++;
      assert (out === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, out, exp);
      end
   endtask

   initial begin
      in = '0; push = 1'b0; spdec = '0; sp = '0; reset = 1'b0;

      // Reset, then sweep every address.
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sp = 3'(i);
         check($sformatf("reset_sp%0d", i), 16'h0000);
      end

      // Single push at top entry.
      push = 1'b1; spdec = 3'd7; in = 16'h1234;
      tick();
      push = 1'b0; sp = 3'd7;
      check("push_rd7", 16'h1234);
      sp = 3'd6;
      check("push_rd6", 16'h0000);

      // Read-select: mem[3]=AAAA, mem[5]=5555.
      push = 1'b1; spdec = 3'd3; in = 16'hAAAA;
      tick();
      spdec = 3'd5; in = 16'h5555;
      tick();
      push = 1'b1; spdec = 3'd3; sp = 3'd5; in = 16'h9999;
`ifdef STACKRAM_BYPASS_EN
      check("sel_push1", 16'h9999);
`else
      check("sel_push1", 16'hAAAA);
`endif
      push = 1'b0;  // withdrawn before the edge, so no write
      check("sel_push0", 16'h5555);
      tick();
      sp = 3'd3;
      check("sel_nowrite3", 16'hAAAA);

      // Push cycle: old value before edge, new value after.
      push = 1'b1; spdec = 3'd4; in = 16'h4444;
`ifdef STACKRAM_BYPASS_EN
      check("wf_before", 16'h4444);
`else
      check("wf_before", 16'h0000);
`endif
      tick();
      in = 16'h0000;
`ifdef STACKRAM_BYPASS_EN
      check("wf_after", 16'h0000);
`else
      check("wf_after", 16'h4444);
`endif
      push = 1'b0; sp = 3'd4;
      check("wf_rd4", 16'h4444);

      // Wrap: sp=0, spdec=7.
      sp = 3'd0; spdec = 3'd7; push = 1'b1; in = 16'hBEEF;
      tick();
      push = 1'b0; sp = 3'd7;
      check("wrap_rd7", 16'hBEEF);
      sp = 3'd0;
      check("wrap_rd0", 16'h0000);

      // Glitch on push mid-cycle, low at the edge: no write.
      spdec = 3'd0; in = 16'h7777; push = 1'bx;
      #2;
      push = 1'b0;
      tick();
      sp = 3'd0;
      check("glitch_rd0", 16'h0000);

      // Reset beats push and clears everything.
      reset = 1'b0; push = 1'b1; spdec = 3'd2; in = 16'hFFFF;
      tick();
      reset = 1'b1; push = 1'b0; sp = 3'd2;
      check("rstpri_rd2", 16'h0000);
      sp = 3'd7;
      check("rstpri_rd7", 16'h0000);
      sp = 3'd3;
      check("rstpri_rd3", 16'h0000);

      // Fill: spdec 7..0 with 1..8, read back sp 7..0.
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; spdec = 3'(7 - i); in = 16'(i + 1);
         tick();
      end
      push = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sp = 3'(7 - i);
         check($sformatf("fill_sp%0d", 7 - i), 16'(i + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stackram.md
STACKRAM -- requirements
Module: stackram

Interface
REQ-001 Parameter dep, default 3: address width; depth = 2**dep entries.
REQ-002 Parameter l, default 16: data word width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge (parent CPU drives ~clk, so writes land on CPU falling edge).
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 in  input  l  data word to write.
REQ-006 push  input  1  write request and read-address select.
REQ-007 spdec  input  dep  write address; read address while push=1.
REQ-008 sp  input  dep  read address while push=0.
REQ-009 out  output  l  combinational read data.
REQ-010 Positional port order SHALL be in, push, spdec, sp, clk, out, reset, so existing stack instantiations stay valid with reset appended.

Function
REQ-011 Storage SHALL be 2**dep words of l bits, register- or latch-free flop array; no other state.
REQ-012 Read address SHALL be spset = push ? spdec : sp.
REQ-013 out SHALL equal mem[spset] combinationally; zero-cycle latency from address or push change.
REQ-014 On rising clk with reset=1 and push=1, mem[spdec] SHALL take in; all other entries unchanged.
REQ-015 With push=0, no entry SHALL change.
REQ-016 During a push cycle, out SHALL show old mem[spdec] before the edge and the new value after it (write-first on the following read), unless REQ-022 applies.
REQ-017 Address arithmetic is done by the parent; spdec = sp-1 wraps modulo 2**dep (sp=0 -> spdec=2**dep-1); the block SHALL accept any address values, no range checks, no overflow/underflow flags.
REQ-018 Simultaneous push and reset=0: reset SHALL win; no write occurs.
REQ-019 X on push outside the setup window SHALL not corrupt memory; only the sampled value at the edge matters.

Reset
REQ-020 On rising clk with reset=0, every entry SHALL become 0; hence out = 0 on the cycle after reset for any address.
REQ-021 Reset asserted mid-sequence SHALL discard all prior contents; no partial-clear state exists.

Configuration
REQ-022 Macro STACKRAM_BYPASS_EN: when defined, out SHALL equal in whenever push=1 (write-through forwarding, value visible before the edge); when undefined, behaviour per REQ-013/REQ-016. The macro SHALL not change the memory contents or write timing.

Structure
REQ-023 Package stackram_pkg SHALL hold default constants STACKRAM_DEP=3 and STACKRAM_L=16, used as the parameter defaults.
REQ-024 Single flat module; no sub-module required; the read mux and write decode SHALL be in this module.

Verification
REQ-025 Reset: hold reset=0 one edge, then sp sweep 0..7, push=0 -> out=0x0000 at every address.
REQ-026 Push: reset=1, push=1, spdec=7, in=0x1234, edge; then push=0, sp=7 -> out=0x1234; sp=6 -> out=0x0000.
REQ-027 Read-select: mem[3]=0xAAAA, mem[5]=0x5555; push=1, spdec=3, sp=5, before edge -> out=0xAAAA (bypass undefined) or in (bypass defined); push=0 -> out=0x5555.
REQ-028 Wrap: sp=0, spdec=7, push=1, in=0xBEEF, edge -> mem[7]=0xBEEF, mem[0] unchanged.
REQ-029 Reset priority: reset=0, push=1, spdec=2, in=0xFFFF, edge -> mem[2]=0x0000.
REQ-030 Fill: eight pushes at spdec 7..0 with values 0x0001..0x0008, then read sp 7..0 -> 0x0001..0x0008 in order.
